// File: rtl/sid_dac_sched.sv
// sid_dac_sched: round-robin time-sharing of a single sid_dac8 serial DAC
// between NUM_CH requesters. Each grant runs one full 8-bit conversion and
// the result is parked in a per-channel output register.
// Optional build macro: SID_DAC_SCHED_CACHE_EN adds a per-channel cache of the
// last converted code. A repeat request for that same code is answered without
// running the DAC.
module sid_dac_sched #(
  parameter int NUM_CH = 3
) (
  input  logic                clk,
  input  logic                iRst,
  input  logic [NUM_CH-1:0]   iReq,
  input  logic [8*NUM_CH-1:0] iData,
  output logic [NUM_CH-1:0]   oAck,
  output logic [NUM_CH-1:0]   oValid,
  output logic [8*NUM_CH-1:0] oOut,
  output logic                oBusy,
  output logic [7:0]          oDacIn,
  output logic                oDacStart,
  input  logic [7:0]          iDacOut
);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_CAPTURE} state_t;

  state_t        r_state;
  logic [CW-1:0] r_ptr;
  logic [CW-1:0] r_ch;
  logic [3:0]    r_cnt;

  logic          w_any;
  logic [CW-1:0] w_ch;
  logic [7:0]    w_code;
  logic          w_hit;

  // Round-robin pick: the nearest requester after r_ptr wins. The loop runs
  // from the farthest candidate to the nearest, so the last match is the winner.
  always_comb begin
    int idx;
    idx   = 0;
    w_any = 1'b0;
    w_ch  = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      idx = (int'(r_ptr) + k) % NUM_CH;
      if (iReq[idx]) begin
        w_any = 1'b1;
        w_ch  = CW'(idx);
      end
    end
  end

  assign w_code = iData[8*w_ch +: 8];

`ifdef SID_DAC_SCHED_CACHE_EN
  logic [NUM_CH-1:0][7:0] r_cache;
  logic [NUM_CH-1:0]      r_cval;

  assign w_hit = w_any && r_cval[w_ch] && (r_cache[w_ch] == w_code);

  // Remember the last converted code per channel. oDacIn still holds the code
  // of the conversion that is being captured.
  always_ff @(posedge clk) begin
    if (!iRst) begin
      r_cval <= '0;
    end else if (r_state == S_CAPTURE) begin
      r_cache[r_ch] <= oDacIn;
      r_cval[r_ch]  <= 1'b1;
    end
  end
`else
  assign w_hit = 1'b0;
`endif

  // Scheduler FSM. Every output is registered, so each state sets the outputs
  // that must be visible in the following cycle.
  always_ff @(posedge clk) begin
    if (!iRst) begin
      r_state   <= S_IDLE;
      r_ptr     <= CW'(NUM_CH - 1);
      r_ch      <= '0;
      r_cnt     <= '0;
      oAck      <= '0;
      oValid    <= '0;
      oOut      <= '0;
      oBusy     <= 1'b0;
      oDacIn    <= '0;
      oDacStart <= 1'b0;
    end else begin
      oAck      <= '0;
      oValid    <= '0;
      oDacStart <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            oAck[w_ch] <= 1'b1;
            if (w_hit) begin
              // Cached result is already in oOut: acknowledge and complete at once.
              oValid[w_ch] <= 1'b1;
              r_ptr        <= w_ch;
            end else begin
              r_ch      <= w_ch;
              oDacIn    <= w_code;
              oDacStart <= 1'b1;
              oBusy     <= 1'b1;
              r_state   <= S_START;
            end
          end
        end
        S_START: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // Nine cycles: eight shift cycles plus the DAC's output latch.
          if (r_cnt == 4'd8) begin
            r_state <= S_CAPTURE;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_CAPTURE: begin
          oOut[8*r_ch +: 8] <= iDacOut;
          oValid[r_ch]      <= 1'b1;
          oBusy             <= 1'b0;
          r_ptr             <= r_ch;
          r_state           <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sid_dac_sched.sv
// Bench for sid_dac_sched. It includes a behavioural sid_dac8 stand-in: the code
// is latched on iStart, and after nine more clocks a slightly non-ideal ladder
// value appears on the output. An event-level scheduler model predicts every
// output in every cycle. Directed scenarios run first, then random traffic.
module tb_sid_dac_sched;
  localparam int N = 3;

  logic           clk = 1'b0;
  logic           iRst;
  logic [N-1:0]   iReq, oAck, oValid;
  logic [8*N-1:0] iData, oOut;
  logic           oBusy, oDacStart;
  logic [7:0]     oDacIn;
  logic [7:0]     iDacOut = 8'h00;

  always #5 clk = ~clk;

  sid_dac_sched #(.NUM_CH(N)) dut (
    .clk(clk), .iRst(iRst), .iReq(iReq), .iData(iData),
    .oAck(oAck), .oValid(oValid), .oOut(oOut), .oBusy(oBusy),
    .oDacIn(oDacIn), .oDacStart(oDacStart), .iDacOut(iDacOut)
  );

  // Ladder transfer with bit weights 2,2,4,8,17,33,65,124 (full scale is 0xff).
  function automatic logic [7:0] dac_f(input logic [7:0] c);
    int w [8];
    int s;
    w = '{2, 2, 4, 8, 17, 33, 65, 124};
    s = 0;
    for (int b = 0; b < 8; b++) if (c[b]) s += w[b];
    return 8'(s);
  endfunction

  // DAC stand-in. It is never reset, and its output only moves at the end of S+9.
  logic [7:0] d_code = 8'h00;
  int         d_cnt  = 0;
  always @(posedge clk) begin
    if (oDacStart === 1'b1) begin
      d_code <= oDacIn;
      d_cnt  <= 9;
    end else if (d_cnt != 0) begin
      d_cnt <= d_cnt - 1;
      if (d_cnt == 1) iDacOut <= dac_f(d_code);
    end
  end

  int n_vec = 0, n_bad = 0;
  int cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  // Reference model state
  int         free_at = 0, gnt = -100, ptr = N - 1, p_ch = -1, p_at = 0;
  logic [7:0] p_code;
  logic [7:0] m_out   [N];
  logic [7:0] m_cache [N];
  bit         m_cval  [N];
  logic [N-1:0] e_ack = '0, e_valid = '0;
  logic       e_start = 1'b0, e_busy = 1'b0;
  logic [7:0] e_dacin = 8'h00;

  // Predict the outputs for cycle cyc+1 from the inputs applied in cycle cyc.
  task automatic model(input logic rst, input logic [N-1:0] req, input logic [8*N-1:0] data);
    int ch;
    logic [7:0] code;
    bit hit;
    e_ack = '0; e_valid = '0; e_start = 1'b0;
    if (!rst) begin
      for (int c = 0; c < N; c++) begin m_out[c] = 8'h00; m_cval[c] = 0; end
      e_dacin = 8'h00; ptr = N - 1; free_at = cyc + 1; gnt = -100; p_ch = -1;
    end else begin
      if (p_ch >= 0 && p_at == cyc + 1) begin
        m_out[p_ch] = dac_f(p_code);
        m_cache[p_ch] = p_code; m_cval[p_ch] = 1;
        e_valid[p_ch] = 1'b1; ptr = p_ch; p_ch = -1;
      end
      if (cyc >= free_at && req != '0) begin
        ch = -1;
        for (int k = 1; k <= N; k++)
          if (ch < 0 && req[(ptr + k) % N]) ch = (ptr + k) % N;
        code = data[8*ch +: 8];
        hit = 0;
`ifdef SID_DAC_SCHED_CACHE_EN
        hit = m_cval[ch] && (m_cache[ch] == code);
`endif
        e_ack[ch] = 1'b1;
        if (hit) begin
          e_valid[ch] = 1'b1; ptr = ch; free_at = cyc + 1;
        end else begin
          e_start = 1'b1; e_dacin = code; gnt = cyc; free_at = cyc + 12;
          p_ch = ch; p_at = cyc + 12; p_code = code;
        end
      end
    end
    e_busy = (cyc + 1 >= gnt + 1) && (cyc + 1 <= gnt + 11);
  endtask

  // Stimulus state and observation log
  logic [N-1:0]   req_s = '0;
  logic [8*N-1:0] data_s = '0;
  bit autodrop = 1;
  int last_ack [N], last_valid [N], cnt_ack [N], cnt_valid [N];
  int gq [$];
  int sq [$];

  task automatic step(input logic rst);
    logic [8*N-1:0] pk;
    @(negedge clk);
    if (autodrop) req_s &= ~e_ack;
    iRst = rst; iReq = req_s; iData = data_s;
    model(rst, req_s, data_s);
    @(posedge clk); #1;
    cyc++;
    for (int c = 0; c < N; c++) pk[8*c +: 8] = m_out[c];
    chk("ack",   32'(oAck),   32'(e_ack));
    chk("valid", 32'(oValid), 32'(e_valid));
    chk("busy",  32'(oBusy),  32'(e_busy));
    chk("start", 32'(oDacStart), 32'(e_start));
    chk("dacin", 32'(oDacIn), 32'(e_dacin));
    chk("out",   32'(oOut),   32'(pk));
    for (int c = 0; c < N; c++) begin
      if (oAck[c] === 1'b1)   begin last_ack[c] = cyc; cnt_ack[c]++; gq.push_back(c); end
      if (oValid[c] === 1'b1) begin last_valid[c] = cyc; cnt_valid[c]++; end
    end
    if (oDacStart === 1'b1) sq.push_back(cyc);
  endtask

  function automatic logic [7:0] pick();
    case ($urandom_range(0, 3))
      0: return 8'h80;
      1: return 8'h33;
      2: return 8'h01;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    int n0, s0, a2, vc1;
    for (int c = 0; c < N; c++) begin
      last_ack[c] = -1; last_valid[c] = -1; cnt_ack[c] = 0; cnt_valid[c] = 0;
      m_out[c] = 8'h00; m_cache[c] = 8'h00; m_cval[c] = 0;
    end
    iRst = 1'b0; iReq = '0; iData = '0;
    step(0); step(0);

    // Single conversion on ch0, code 0x80
    data_s[7:0] = 8'h80; req_s = 3'b001; n0 = cyc;
    repeat (14) step(1);
    chk("t1_ack_at",   32'(last_ack[0] - n0),   32'd1);
    chk("t1_valid_at", 32'(last_valid[0] - n0), 32'd12);
    chk("t1_out0",     32'(oOut[7:0]),          32'h7c);

    // Three simultaneous requests are served in order, 12 cycles apart
    step(0);
    data_s = {8'hff, 8'h01, 8'h00}; req_s = 3'b111;
    sq.delete(); gq.delete();
    repeat (40) step(1);
    chk("t2_out", 32'(oOut), 32'hff0200);
    chk("t2_nstart", 32'(sq.size()), 32'd3);
    if (sq.size() >= 3) begin
      chk("t2_gap01", 32'(sq[1] - sq[0]), 32'd12);
      chk("t2_gap12", 32'(sq[2] - sq[1]), 32'd12);
      chk("t2_order", 32'(gq[0] * 16 + gq[1] * 4 + gq[2]), 32'h06);
    end

    // All three requests held continuously: strict rotation
    step(0);
    autodrop = 0; data_s = {8'h44, 8'h22, 8'h11}; req_s = 3'b111; gq.delete();
    for (int i = 0; i < 200 && gq.size() < 8; i++) step(1);
    chk("t3_ngrant", 32'(gq.size() >= 8), 32'd1);
    for (int i = 0; i < 8 && i < gq.size(); i++) chk("t3_rr", 32'(gq[i]), 32'(i % 3));
    req_s = '0; autodrop = 1;
    repeat (14) step(1);

    // Reset in the middle of a ch1 conversion
    step(0);
    data_s[15:8] = 8'h5a; req_s = 3'b010;
    step(1);
    repeat (5) step(1);
    step(0);
    chk("t4_out0",   32'(oOut),   32'd0);
    chk("t4_dacin0", 32'(oDacIn), 32'd0);
    vc1 = cnt_valid[1];
    repeat (15) step(1);
    chk("t4_novalid", 32'(cnt_valid[1] - vc1), 32'd0);
    data_s[15:8] = 8'h33; req_s = 3'b010;
    repeat (14) step(1);
    chk("t4_fresh", 32'(oOut[15:8]), 32'(dac_f(8'h33)));

    // One-cycle ch2 pulse while busy is dropped
    data_s[7:0] = 8'h21; req_s = 3'b001; s0 = sq.size();
    step(1); step(1); step(1);
    req_s[2] = 1'b1; data_s[23:16] = 8'h99; a2 = cnt_ack[2];
    step(1);
    req_s[2] = 1'b0;
    repeat (14) step(1);
    chk("t5_noack2", 32'(cnt_ack[2] - a2), 32'd0);
    chk("t5_starts", 32'(sq.size() - s0), 32'd1);

    // Repeat of the same code on ch0
    step(0);
    data_s[7:0] = 8'h80; req_s = 3'b001;
    repeat (14) step(1);
    n0 = cyc; s0 = sq.size(); req_s = 3'b001;
    repeat (14) step(1);
    chk("t6_ack_at", 32'(last_ack[0] - n0), 32'd1);
`ifdef SID_DAC_SCHED_CACHE_EN
    chk("t6_valid_at", 32'(last_valid[0] - n0), 32'd1);
    chk("t6_starts",   32'(sq.size() - s0),     32'd0);
`else
    chk("t6_valid_at", 32'(last_valid[0] - n0), 32'd12);
    chk("t6_starts",   32'(sq.size() - s0),     32'd1);
`endif
    chk("t6_out0", 32'(oOut[7:0]), 32'h7c);

    // Random traffic, with occasional drops, data changes and resets
    gq.delete(); sq.delete();
    for (int i = 0; i < 2500; i++) begin
      for (int c = 0; c < N; c++) begin
        if (!req_s[c] && $urandom_range(0, 5) == 0) begin
          req_s[c] = 1'b1; data_s[8*c +: 8] = pick();
        end else if (req_s[c] && $urandom_range(0, 60) == 0) begin
          req_s[c] = 1'b0;
        end
        if ($urandom_range(0, 15) == 0) data_s[8*c +: 8] = pick();
      end
      step($urandom_range(0, 400) != 0);
    end
    req_s = '0;
    repeat (14) step(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
